// File: rtl/axi_arw_arbiter.sv
// Schedules AXI AW/AR requests onto one half-duplex ARW command port: weighted round-robin
// with per-direction run caps and outstanding limits. Define ARW_ARB_STAT_EN for statistics.
module axi_arw_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int WR_BURST_MAX    = 4,
  parameter int RD_BURST_MAX    = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awlock,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arlock,
  output logic                  m_arw_valid,
  input  logic                  m_arw_ready,
  output logic [ADDR_WIDTH-1:0] m_arw_addr,
  output logic [ID_WIDTH-1:0]   m_arw_id,
  output logic [7:0]            m_arw_len,
  output logic [2:0]            m_arw_size,
  output logic [1:0]            m_arw_burst,
  output logic [1:0]            m_arw_lock,
  output logic                  m_arw_write,
  input  logic                  b_valid,
  input  logic                  b_ready,
  input  logic                  r_valid,
  input  logic                  r_ready,
  input  logic                  r_last,
  output logic [7:0]            wr_outstanding,
  output logic [7:0]            rd_outstanding
`ifdef ARW_ARB_STAT_EN
  ,
  output logic [31:0]           stat_wr_grants,
  output logic [31:0]           stat_rd_grants,
  output logic [31:0]           stat_limit_stalls
`endif
);

  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);
  localparam logic [7:0] WR_CAP  = 8'(WR_BURST_MAX);
  localparam logic [7:0] RD_CAP  = 8'(RD_BURST_MAX);
  localparam int DIR_RD = 0;
  localparam int DIR_WR = 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t     state_reg;
  logic       last_write_reg;
  logic [7:0] run_reg;
  logic       lock_reg;

  logic [1:0] req;
  logic [1:0] rsp;
  logic [1:0] room;
  logic [1:0] inc;
  logic [1:0] dec;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       cmd_hs;

  // Bit index is the direction: 0 = read, 1 = write.
  assign req    = {s_awvalid, s_arvalid};
  assign rsp    = {b_valid & b_ready, r_valid & r_ready & r_last};
  assign cmd_hs = m_arw_valid & m_arw_ready;
  assign elig   = req & room;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      logic [7:0] count_reg;

      assign room[gi] = (count_reg < MAX_OUT);
      assign inc[gi]  = cmd_hs && (m_arw_write == 1'(gi));
      // A response with nothing in flight is ignored rather than wrapping the counter.
      assign dec[gi]  = rsp[gi] && (count_reg != 8'd0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= 8'd0;
        end else if (inc[gi] && !dec[gi]) begin
          count_reg <= count_reg + 8'd1;
        end else if (dec[gi] && !inc[gi]) begin
          count_reg <= count_reg - 8'd1;
        end
      end

`ifdef ARW_ARB_STAT_EN
      logic [31:0] grants_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          grants_reg <= 32'd0;
        end else if (inc[gi] && (grants_reg != 32'hFFFF_FFFF)) begin
          grants_reg <= grants_reg + 32'd1;
        end
      end
`endif
    end
  endgenerate

  assign wr_outstanding = g_dir[DIR_WR].count_reg;
  assign rd_outstanding = g_dir[DIR_RD].count_reg;

  // Under contention the last direction keeps the channel until its run reaches the cap.
  always_comb begin
    grant = 2'b00;
    if (!rst && (state_reg == IDLE)) begin
      if (elig[DIR_WR] && elig[DIR_RD]) begin
        if (last_write_reg) begin
          if (run_reg < WR_CAP) grant[DIR_WR] = 1'b1;
          else                  grant[DIR_RD] = 1'b1;
        end else begin
          if (run_reg < RD_CAP) grant[DIR_RD] = 1'b1;
          else                  grant[DIR_WR] = 1'b1;
        end
      end else begin
        grant = elig;
      end
    end
  end

  assign s_awready  = grant[DIR_WR];
  assign s_arready  = grant[DIR_RD];
  assign m_arw_lock = {1'b0, lock_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      m_arw_valid    <= 1'b0;
      m_arw_addr     <= '0;
      m_arw_id       <= '0;
      m_arw_len      <= 8'd0;
      m_arw_size     <= 3'd0;
      m_arw_burst    <= 2'd0;
      m_arw_write    <= 1'b0;
      lock_reg       <= 1'b0;
      last_write_reg <= 1'b0;
      run_reg        <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            state_reg   <= ISSUE;
            m_arw_valid <= 1'b1;
            m_arw_write <= grant[DIR_WR];
            if (grant[DIR_WR]) begin
              m_arw_addr  <= s_awaddr;
              m_arw_id    <= s_awid;
              m_arw_len   <= s_awlen;
              m_arw_size  <= s_awsize;
              m_arw_burst <= s_awburst;
              lock_reg    <= s_awlock;
            end else begin
              m_arw_addr  <= s_araddr;
              m_arw_id    <= s_arid;
              m_arw_len   <= s_arlen;
              m_arw_size  <= s_arsize;
              m_arw_burst <= s_arburst;
              lock_reg    <= s_arlock;
            end
            if (grant[DIR_WR] == last_write_reg) begin
              if (run_reg != 8'hFF) run_reg <= run_reg + 8'd1;
            end else begin
              run_reg        <= 8'd1;
              last_write_reg <= grant[DIR_WR];
            end
          end
        end
        ISSUE: begin
          if (m_arw_ready) begin
            state_reg   <= IDLE;
            m_arw_valid <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          m_arw_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARW_ARB_STAT_EN
  logic        stall;
  logic [31:0] stalls_reg;

  assign stall = |(req & ~room);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalls_reg <= 32'd0;
    end else if (stall && (stalls_reg != 32'hFFFF_FFFF)) begin
      stalls_reg <= stalls_reg + 32'd1;
    end
  end

  assign stat_wr_grants    = g_dir[DIR_WR].grants_reg;
  assign stat_rd_grants    = g_dir[DIR_RD].grants_reg;
  assign stat_limit_stalls = stalls_reg;
`endif

endmodule

// File: tb/tb_axi_arw_arbiter.sv
// Self-checking bench for axi_arw_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a queue-based reference model.
module tb_axi_arw_arbiter;

  localparam int AW   = 32;
  localparam int IW   = 8;
  localparam int WRB  = 4;
  localparam int RDB  = 4;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_awvalid, s_awready, s_awlock;
  logic [IW-1:0] s_awid;
  logic [AW-1:0] s_awaddr;
  logic [7:0]    s_awlen;
  logic [2:0]    s_awsize;
  logic [1:0]    s_awburst;
  logic          s_arvalid, s_arready, s_arlock;
  logic [IW-1:0] s_arid;
  logic [AW-1:0] s_araddr;
  logic [7:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst;
  logic          m_arw_valid, m_arw_ready, m_arw_write;
  logic [AW-1:0] m_arw_addr;
  logic [IW-1:0] m_arw_id;
  logic [7:0]    m_arw_len;
  logic [2:0]    m_arw_size;
  logic [1:0]    m_arw_burst, m_arw_lock;
  logic          b_valid, b_ready, r_valid, r_ready, r_last;
  logic [7:0]    wr_outstanding, rd_outstanding;
`ifdef ARW_ARB_STAT_EN
  logic [31:0]   stat_wr_grants, stat_rd_grants, stat_limit_stalls;
`endif

  always #5 clk = ~clk;

  axi_arw_arbiter #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .WR_BURST_MAX(WRB), .RD_BURST_MAX(RDB),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
    .m_arw_valid(m_arw_valid), .m_arw_ready(m_arw_ready), .m_arw_addr(m_arw_addr),
    .m_arw_id(m_arw_id), .m_arw_len(m_arw_len), .m_arw_size(m_arw_size),
    .m_arw_burst(m_arw_burst), .m_arw_lock(m_arw_lock), .m_arw_write(m_arw_write),
    .b_valid(b_valid), .b_ready(b_ready), .r_valid(r_valid), .r_ready(r_ready),
    .r_last(r_last), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
`ifdef ARW_ARB_STAT_EN
    , .stat_wr_grants(stat_wr_grants), .stat_rd_grants(stat_rd_grants),
    .stat_limit_stalls(stat_limit_stalls)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One line per command handed to the DDR side.
  always @(negedge clk) begin
    if (!rst && m_arw_valid && m_arw_ready)
      $display("txn %0t %s addr=0x%08h id=0x%02h len=%0d wr_out=%0d rd_out=%0d", $time,
               m_arw_write ? "WR" : "RD", m_arw_addr, m_arw_id, m_arw_len,
               wr_outstanding, rd_outstanding);
  end

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic       aw_v, ar_v, rdy, b, r;
    logic       e_awr, e_arr, e_v, e_w;
    logic [7:0] e_wo, e_ro;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input int aw, input int ar, input int rd, input int b,
                              input int r, input int ea, input int er, input int ev,
                              input int ew, input int wo, input int ro);
    vec_t v;
    v.aw_v = 1'(aw); v.ar_v = 1'(ar); v.rdy = 1'(rd); v.b = 1'(b); v.r = 1'(r);
    v.e_awr = 1'(ea); v.e_arr = 1'(er); v.e_v = 1'(ev); v.e_w = 1'(ew);
    v.e_wo = 8'(wo); v.e_ro = 8'(ro);
    return v;
  endfunction

  task automatic clear_inputs();
    s_awvalid = 0; s_awid = '0; s_awaddr = '0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_awlock = 0;
    s_arvalid = 0; s_arid = '0; s_araddr = '0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_arlock = 0;
    m_arw_ready = 0; b_valid = 0; b_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [1:0]    lock;
  } cmd_t;

  cmd_t pend[$];      // command waiting on the shared port
  int   wr_q[$];      // IDs of writes in flight
  int   rd_q[$];      // IDs of reads in flight
  bit   hist[$];      // grant history, 1 = write

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0 && n < 255; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic logic [1:0] model_grant();
    bit we, re, lw;
    int cap;
    if (pend.size() != 0) return 2'b00;
    we = s_awvalid && (wr_q.size() < MAXO);
    re = s_arvalid && (rd_q.size() < MAXO);
    if (we && re) begin
      lw  = (hist.size() != 0) && hist[hist.size()-1];
      cap = lw ? WRB : RDB;
      if (run_len() < cap) return lw ? 2'b10 : 2'b01;
      return lw ? 2'b01 : 2'b10;
    end
    return {we, re};
  endfunction

  task automatic model_check_and_step();
    logic [1:0] g;
    cmd_t act, c;
    g = model_grant();
    chk("rnd_awready", 64'(s_awready), 64'(g[1]));
    chk("rnd_arready", 64'(s_arready), 64'(g[0]));
    chk("rnd_valid", 64'(m_arw_valid), 64'(pend.size() != 0));
    chk("rnd_wr_out", 64'(wr_outstanding), 64'(wr_q.size()));
    chk("rnd_rd_out", 64'(rd_outstanding), 64'(rd_q.size()));
    if (pend.size() != 0) begin
      act = {m_arw_write, m_arw_addr, m_arw_id, m_arw_len, m_arw_size, m_arw_burst, m_arw_lock};
      chk("rnd_payload", 64'(act), 64'(pend[0]));
    end
    if (b_valid && b_ready && wr_q.size() != 0) void'(wr_q.pop_front());
    if (r_valid && r_ready && r_last && rd_q.size() != 0) void'(rd_q.pop_front());
    if (pend.size() != 0 && m_arw_ready) begin
      c = pend.pop_front();
      if (c.write) wr_q.push_back(int'(c.id));
      else         rd_q.push_back(int'(c.id));
    end
    if (g[1]) begin
      pend.push_back('{1'b1, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst, {1'b0, s_awlock}});
      hist.push_back(1'b1);
    end else if (g[0]) begin
      pend.push_back('{1'b0, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, {1'b0, s_arlock}});
      hist.push_back(1'b0);
    end
    if (hist.size() > 300) void'(hist.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // c0..c7: reads keep the port (initial last=read); r_last with issue keeps rd_out at 1.
    // c8..c15: writes take four turns; c16 switches back; c18..c23 exercise the limit of 2.
    tbl[0]  = mk(1,1,1,0,0, 0,1,0,0, 0,0);
    tbl[1]  = mk(1,1,1,0,0, 0,0,1,0, 0,0);
    tbl[2]  = mk(1,1,1,0,0, 0,1,0,0, 0,1);
    tbl[3]  = mk(1,1,1,0,1, 0,0,1,0, 0,1);
    tbl[4]  = mk(1,1,1,0,0, 0,1,0,0, 0,1);
    tbl[5]  = mk(1,1,1,0,1, 0,0,1,0, 0,1);
    tbl[6]  = mk(1,1,1,0,0, 0,1,0,0, 0,1);
    tbl[7]  = mk(1,1,1,0,1, 0,0,1,0, 0,1);
    tbl[8]  = mk(1,1,1,0,0, 1,0,0,0, 0,1);
    tbl[9]  = mk(1,1,1,0,0, 0,0,1,1, 0,1);
    tbl[10] = mk(1,1,1,0,0, 1,0,0,1, 1,1);
    tbl[11] = mk(1,1,1,1,0, 0,0,1,1, 1,1);
    tbl[12] = mk(1,1,1,0,0, 1,0,0,1, 1,1);
    tbl[13] = mk(1,1,1,1,0, 0,0,1,1, 1,1);
    tbl[14] = mk(1,1,1,0,0, 1,0,0,1, 1,1);
    tbl[15] = mk(1,1,1,1,0, 0,0,1,1, 1,1);
    tbl[16] = mk(1,1,1,0,0, 0,1,0,1, 1,1);
    tbl[17] = mk(1,1,1,0,0, 0,0,1,0, 1,1);
    tbl[18] = mk(1,1,1,0,0, 1,0,0,0, 1,2);
    tbl[19] = mk(1,1,1,0,0, 0,0,1,1, 1,2);
    tbl[20] = mk(1,1,1,0,0, 0,0,0,1, 2,2);
    tbl[21] = mk(1,1,1,0,1, 0,0,0,1, 2,2);
    tbl[22] = mk(1,1,1,0,0, 0,1,0,1, 2,1);
    tbl[23] = mk(1,1,1,1,0, 0,0,1,0, 2,1);
    tbl[24] = mk(0,1,1,0,0, 0,0,0,0, 1,2);
    tbl[25] = mk(0,0,1,0,1, 0,0,0,0, 1,2);
    tbl[26] = mk(0,0,1,0,1, 0,0,0,0, 1,1);
    tbl[27] = mk(0,0,1,1,0, 0,0,0,0, 1,0);
    tbl[28] = mk(0,0,1,0,0, 0,0,0,0, 0,0);

    // Reset state, with both requests raised: readies must stay low while in reset.
    clear_inputs();
    s_awvalid = 1; s_arvalid = 1;
    @(negedge clk);
    chk("rst_awready", 64'(s_awready), 64'(0));
    chk("rst_arready", 64'(s_arready), 64'(0));
    chk("rst_valid", 64'(m_arw_valid), 64'(0));
    chk("rst_addr", 64'(m_arw_addr), 64'(0));
    chk("rst_wr_out", 64'(wr_outstanding), 64'(0));
    chk("rst_rd_out", 64'(rd_outstanding), 64'(0));
    s_awvalid = 0; s_arvalid = 0;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Single write.
    s_awvalid = 1; s_awaddr = 32'h1000; s_awlen = 8'd7; s_awid = 8'h5A;
    s_awsize = 3'd3; s_awburst = 2'd1; m_arw_ready = 1;
    @(negedge clk);
    chk("sw_awready", 64'(s_awready), 64'(1));
    chk("sw_arready", 64'(s_arready), 64'(0));
    chk("sw_valid_early", 64'(m_arw_valid), 64'(0));
    @(posedge clk); #1 s_awvalid = 0;
    @(negedge clk);
    chk("sw_valid", 64'(m_arw_valid), 64'(1));
    chk("sw_write", 64'(m_arw_write), 64'(1));
    chk("sw_addr", 64'(m_arw_addr), 64'(32'h1000));
    chk("sw_len", 64'(m_arw_len), 64'(7));
    chk("sw_id", 64'(m_arw_id), 64'(8'h5A));
    chk("sw_awready_issue", 64'(s_awready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_valid_drop", 64'(m_arw_valid), 64'(0));
    chk("sw_wr_out1", 64'(wr_outstanding), 64'(1));
    @(posedge clk); #1 b_valid = 1; b_ready = 1;
    @(posedge clk); #1 b_valid = 0; b_ready = 0;
    @(negedge clk);
    chk("sw_wr_out0", 64'(wr_outstanding), 64'(0));

    // Contention, limits and simultaneous inc/dec from the table.
    do_reset();
    s_awaddr = 32'h0000_A000; s_araddr = 32'h0000_B000;
    for (int i = 0; i < 29; i++) begin
      s_awvalid = tbl[i].aw_v; s_arvalid = tbl[i].ar_v; m_arw_ready = tbl[i].rdy;
      b_valid = tbl[i].b; b_ready = tbl[i].b;
      r_valid = tbl[i].r; r_ready = tbl[i].r; r_last = tbl[i].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_awready", i), 64'(s_awready), 64'(tbl[i].e_awr));
      chk($sformatf("tbl%0d_arready", i), 64'(s_arready), 64'(tbl[i].e_arr));
      chk($sformatf("tbl%0d_valid", i), 64'(m_arw_valid), 64'(tbl[i].e_v));
      chk($sformatf("tbl%0d_write", i), 64'(m_arw_write), 64'(tbl[i].e_w));
      chk($sformatf("tbl%0d_wr_out", i), 64'(wr_outstanding), 64'(tbl[i].e_wo));
      chk($sformatf("tbl%0d_rd_out", i), 64'(rd_outstanding), 64'(tbl[i].e_ro));
      @(posedge clk); #1;
    end

    // Backpressure: ten stalled cycles, handshake on the eleventh.
    do_reset();
    s_arvalid = 1; s_araddr = 32'h0000_A0A0; s_arid = 8'h33; s_arlen = 8'd3;
    s_awaddr = 32'h0000_2000;
    @(negedge clk);
    chk("bp_arready", 64'(s_arready), 64'(1));
    @(posedge clk); #1;
    s_arvalid = 0; s_awvalid = 1; s_araddr = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), 64'(m_arw_valid), 64'(1));
      chk($sformatf("bp_addr%0d", k), 64'(m_arw_addr), 64'(32'h0000_A0A0));
      chk($sformatf("bp_awready%0d", k), 64'(s_awready), 64'(0));
      @(posedge clk); #1;
    end
    m_arw_ready = 1;
    @(negedge clk);
    chk("bp_valid_hs", 64'(m_arw_valid), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_after", 64'(m_arw_valid), 64'(0));
    chk("bp_awready_next", 64'(s_awready), 64'(1));
    chk("bp_rd_out", 64'(rd_outstanding), 64'(1));
    @(posedge clk); #1 s_awvalid = 0;
    @(negedge clk);
    chk("bp_wr_issue", 64'(m_arw_write), 64'(1));
    chk("bp_wr_addr", 64'(m_arw_addr), 64'(32'h0000_2000));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of ISSUE.
    s_awvalid = 1; m_arw_ready = 0;
    @(negedge clk);
    chk("ar_awready", 64'(s_awready), 64'(1));
    @(posedge clk); #1 s_awvalid = 0;
    @(negedge clk);
    chk("ar_valid_pre", 64'(m_arw_valid), 64'(1));
    chk("ar_wr_out_pre", 64'(wr_outstanding), 64'(1));
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("ar_valid_async", 64'(m_arw_valid), 64'(0));
    chk("ar_wr_out_async", 64'(wr_outstanding), 64'(0));
    chk("ar_rd_out_async", 64'(rd_outstanding), 64'(0));
    chk("ar_addr_async", 64'(m_arw_addr), 64'(0));
    @(posedge clk); #2 rst = 1'b0;
    s_awvalid = 1; m_arw_ready = 1;
    @(negedge clk);
    chk("ar_first_awready", 64'(s_awready), 64'(1));
    chk("ar_first_arready", 64'(s_arready), 64'(0));
    @(posedge clk); #1 s_awvalid = 0;
    @(negedge clk);
    chk("ar_first_write", 64'(m_arw_write), 64'(1));

    // Randomized traffic against the reference model.
    do_reset();
    pend.delete(); wr_q.delete(); rd_q.delete(); hist.delete();
    for (int n = 0; n < 1500; n++) begin
      s_awvalid = 1'($urandom_range(0, 1));
      s_arvalid = 1'($urandom_range(0, 1));
      s_awaddr = $urandom; s_awid = 8'($urandom); s_awlen = 8'($urandom);
      s_awsize = 3'($urandom); s_awburst = 2'($urandom); s_awlock = 1'($urandom);
      s_araddr = $urandom; s_arid = 8'($urandom); s_arlen = 8'($urandom);
      s_arsize = 3'($urandom); s_arburst = 2'($urandom); s_arlock = 1'($urandom);
      m_arw_ready = ($urandom_range(0, 3) != 0);
      if (wr_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        b_valid = 1; b_ready = 1;
      end else begin
        b_valid = 1'($urandom_range(0, 1)); b_ready = 0;
      end
      if (rd_q.size() != 0 && $urandom_range(0, 2) == 0) begin
        r_valid = 1; r_ready = 1; r_last = 1;
      end else begin
        r_valid = 1'($urandom_range(0, 1)); r_ready = 1'($urandom_range(0, 1)); r_last = 0;
      end
      @(negedge clk);
      model_check_and_step();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
